// File: rtl/lsb_embed_ctrl.sv
// lsb_embed_ctrl: feeds message bits MSB-first, one per audio sample, through a single-sample LSB bit changer.
// Optional macro LSB_EMBED_LEN_HEADER_EN prefixes the message with its LEN_W-bit length, MSB-first.
module lsb_embed_ctrl #(
    parameter int BPS   = 24,
    parameter int LEN_W = 16
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic [LEN_W-1:0] in_msg_len,
    input  logic             in_byte_valid,
    input  logic [7:0]       in_byte,
    output logic             out_byte_ready,
    input  logic             in_sample_valid,
    input  logic [BPS-1:0]   in_sample,
    output logic             out_sample_ready,
    output logic             out_bc_enable,
    output logic [BPS-1:0]   out_bc_frame,
    output logic             out_bc_message,
    input  logic [BPS-1:0]   in_bc_frame,
    input  logic             in_bc_ready,
    output logic             out_sample_valid,
    output logic [BPS-1:0]   out_sample,
    input  logic             in_dst_ready,
    output logic             out_busy,
    output logic             out_done
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_SMP = 3'd2,
        ISSUE    = 3'd3,
        WAIT_BC  = 3'd4,
        OUTPUT   = 3'd5,
        DONE     = 3'd6,
        HEADER   = 3'd7
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [LEN_W-1:0] bytes_left_r;
    logic [7:0]       shift_r;
    logic [2:0]       bit_idx_r;

    logic             out_byte_ready_r;
    logic             out_sample_ready_r;
    logic             out_bc_enable_r;
    logic [BPS-1:0]   out_bc_frame_r;
    logic             out_bc_message_r;
    logic             out_sample_valid_r;
    logic [BPS-1:0]   out_sample_r;
    logic             out_busy_r;
    logic             out_done_r;

    logic             byte_hs_s;
    logic             smp_hs_s;
    logic             bc_done_s;
    logic             dst_hs_s;
    logic             zero_len_s;
    logic             cur_bit_s;
    logic             hdr_active_s;
    logic             hdr_last_s;
    logic             hdr_bit_s;

    assign byte_hs_s  = (state_r == FETCH) && in_byte_valid && out_byte_ready_r;
    assign smp_hs_s   = (state_r == WAIT_SMP) && in_sample_valid && out_sample_ready_r;
    assign bc_done_s  = (state_r == WAIT_BC) && in_bc_ready;
    assign dst_hs_s   = (state_r == OUTPUT) && out_sample_valid_r && in_dst_ready;
    assign cur_bit_s  = hdr_active_s ? hdr_bit_s : shift_r[7];

`ifdef LSB_EMBED_LEN_HEADER_EN
    localparam logic   HDR_EN   = 1'b1;
    localparam state_t FIRST_ST = HEADER;
    localparam int     HW       = (LEN_W > 1) ? $clog2(LEN_W) : 1;

    logic [LEN_W-1:0] len_r;
    logic             hdr_active_r;
    logic [HW-1:0]    hdr_idx_r;

    // Header sequencing: the latched length is walked MSB-first before any message byte.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            len_r        <= {LEN_W{1'b0}};
            hdr_active_r <= 1'b0;
            hdr_idx_r    <= {HW{1'b0}};
        end else begin
            if ((state_r == IDLE) && in_start) begin
                len_r <= in_msg_len;
            end
            if (state_r == HEADER) begin
                hdr_active_r <= 1'b1;
                hdr_idx_r    <= HW'(LEN_W - 1);
            end else if (dst_hs_s && hdr_active_r) begin
                if (hdr_idx_r != {HW{1'b0}}) begin
                    hdr_idx_r <= hdr_idx_r - 1'b1;
                end else begin
                    hdr_active_r <= 1'b0;
                end
            end
        end
    end

    assign hdr_active_s = hdr_active_r;
    assign hdr_last_s   = (hdr_idx_r == {HW{1'b0}});
    assign hdr_bit_s    = len_r[hdr_idx_r];
`else
    localparam logic   HDR_EN   = 1'b0;
    localparam state_t FIRST_ST = FETCH;

    assign hdr_active_s = 1'b0;
    assign hdr_last_s   = 1'b1;
    assign hdr_bit_s    = 1'b0;
`endif

    // A zero-length start with no header completes without leaving IDLE.
    assign zero_len_s = (state_r == IDLE) && in_start &&
                        (in_msg_len == {LEN_W{1'b0}}) && !HDR_EN;

    // State register.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_start && ((in_msg_len != {LEN_W{1'b0}}) || HDR_EN)) begin
                    state_s = FIRST_ST;
                end else begin
                    state_s = IDLE;
                end
            end
            HEADER: state_s = WAIT_SMP;
            FETCH: begin
                if (byte_hs_s) state_s = WAIT_SMP;
                else           state_s = FETCH;
            end
            WAIT_SMP: begin
                if (smp_hs_s) state_s = ISSUE;
                else          state_s = WAIT_SMP;
            end
            // A ready left high by the previous transaction must drop before a new enable.
            ISSUE: begin
                if (!in_bc_ready) state_s = WAIT_BC;
                else              state_s = ISSUE;
            end
            WAIT_BC: begin
                if (in_bc_ready) state_s = OUTPUT;
                else             state_s = WAIT_BC;
            end
            OUTPUT: begin
                if (!dst_hs_s) begin
                    state_s = OUTPUT;
                end else if (hdr_active_s ? !hdr_last_s : (bit_idx_r != 3'd0)) begin
                    state_s = WAIT_SMP;
                end else if (bytes_left_r != {LEN_W{1'b0}}) begin
                    state_s = FETCH;
                end else begin
                    state_s = DONE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Registered outputs, byte serialiser and sample datapath.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            out_byte_ready_r   <= 1'b0;
            out_sample_ready_r <= 1'b0;
            out_bc_enable_r    <= 1'b0;
            out_bc_frame_r     <= {BPS{1'b0}};
            out_bc_message_r   <= 1'b0;
            out_sample_valid_r <= 1'b0;
            out_sample_r       <= {BPS{1'b0}};
            out_busy_r         <= 1'b0;
            out_done_r         <= 1'b0;
            bytes_left_r       <= {LEN_W{1'b0}};
            shift_r            <= 8'h00;
            bit_idx_r          <= 3'd0;
        end else begin
            out_byte_ready_r   <= (state_s == FETCH);
            out_sample_ready_r <= (state_s == WAIT_SMP);
            out_bc_enable_r    <= (state_r == ISSUE) && !in_bc_ready;
            out_busy_r         <= (state_s != IDLE) && (state_s != DONE);
            out_done_r         <= (state_s == DONE) || zero_len_s;

            if ((state_r == IDLE) && in_start) begin
                bytes_left_r <= in_msg_len;
            end else if (byte_hs_s) begin
                bytes_left_r <= bytes_left_r - 1'b1;
            end

            if (byte_hs_s) begin
                shift_r   <= in_byte;
                bit_idx_r <= 3'd7;
            end else if (dst_hs_s && !hdr_active_s && (bit_idx_r != 3'd0)) begin
                shift_r   <= {shift_r[6:0], 1'b0};
                bit_idx_r <= bit_idx_r - 1'b1;
            end

            if (smp_hs_s) begin
                out_bc_frame_r   <= in_sample;
                out_bc_message_r <= cur_bit_s;
            end

            if (bc_done_s) begin
                out_sample_r       <= in_bc_frame;
                out_sample_valid_r <= 1'b1;
            end else if (dst_hs_s) begin
                out_sample_valid_r <= 1'b0;
            end
        end
    end

    assign out_byte_ready   = out_byte_ready_r;
    assign out_sample_ready = out_sample_ready_r;
    assign out_bc_enable    = out_bc_enable_r;
    assign out_bc_frame     = out_bc_frame_r;
    assign out_bc_message   = out_bc_message_r;
    assign out_sample_valid = out_sample_valid_r;
    assign out_sample       = out_sample_r;
    assign out_busy         = out_busy_r;
    assign out_done         = out_done_r;

endmodule

// File: tb/tb_lsb_embed_ctrl.sv
// Self-checking bench for lsb_embed_ctrl: behavioural bit changer plus a scoreboard of expected embedded samples.
module tb_lsb_embed_ctrl;

    localparam int BPS   = 24;
    localparam int LEN_W = 16;

    logic             in_clk = 1'b0;
    logic             in_rst_n = 1'b0;
    logic             in_start = 1'b0;
    logic [LEN_W-1:0] in_msg_len = '0;
    logic             in_byte_valid = 1'b0;
    logic [7:0]       in_byte = 8'h00;
    logic             out_byte_ready;
    logic             in_sample_valid = 1'b0;
    logic [BPS-1:0]   in_sample = '0;
    logic             out_sample_ready;
    logic             out_bc_enable;
    logic [BPS-1:0]   out_bc_frame;
    logic             out_bc_message;
    logic [BPS-1:0]   in_bc_frame = '0;
    logic             in_bc_ready = 1'b0;
    logic             out_sample_valid;
    logic [BPS-1:0]   out_sample;
    logic             in_dst_ready = 1'b0;
    logic             out_busy;
    logic             out_done;

    int compared = 0;
    int mismatched = 0;
    int hold_cfg = 1;

    logic [7:0]     msg_q[$];
    logic [BPS-1:0] smp_q[$];
    logic           bit_q[$];
    logic [BPS-1:0] exp_q[$];

    lsb_embed_ctrl #(.BPS(BPS), .LEN_W(LEN_W)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_start(in_start), .in_msg_len(in_msg_len),
        .in_byte_valid(in_byte_valid), .in_byte(in_byte), .out_byte_ready(out_byte_ready),
        .in_sample_valid(in_sample_valid), .in_sample(in_sample), .out_sample_ready(out_sample_ready),
        .out_bc_enable(out_bc_enable), .out_bc_frame(out_bc_frame), .out_bc_message(out_bc_message),
        .in_bc_frame(in_bc_frame), .in_bc_ready(in_bc_ready),
        .out_sample_valid(out_sample_valid), .out_sample(out_sample), .in_dst_ready(in_dst_ready),
        .out_busy(out_busy), .out_done(out_done)
    );

    always #5 in_clk = ~in_clk;

    // Ideal bit changer: result ready 3 cycles after enable, ready held for hold_cfg cycles; never reset.
    logic [1:0]     bc_cnt = 2'd0;
    int             bc_hold = 0;
    logic [BPS-1:0] bc_res = '0;
    always @(posedge in_clk) begin
        if (out_bc_enable) begin
            bc_cnt      <= 2'd3;
            in_bc_ready <= 1'b0;
            bc_res      <= {out_bc_frame[BPS-1:1], out_bc_message};
        end else if (bc_cnt != 2'd0) begin
            bc_cnt <= bc_cnt - 2'd1;
            if (bc_cnt == 2'd1) begin
                in_bc_ready <= 1'b1;
                in_bc_frame <= bc_res;
                bc_hold     <= hold_cfg;
            end
        end else if (bc_hold != 0) begin
            bc_hold <= bc_hold - 1;
            if (bc_hold == 1) in_bc_ready <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 64'({out_byte_ready, out_sample_ready, out_bc_enable, out_bc_message,
                                out_sample_valid, out_busy, out_done}), 64'd0);
        chk({tag, "_bc_frame"}, 64'(out_bc_frame), 64'd0);
        chk({tag, "_sample"}, 64'(out_sample), 64'd0);
    endtask

    // Runs one message; all inputs change on the falling edge, handshakes resolve on the next rising edge.
    task automatic run_msg(input int len, input int stall_at, input bit abort, output bit aborted);
        int byte_i = 0, smp_i = 0, out_n = 0, done_n = 0, en_n = 0, en_bad = 0;
        int bready_n = 0, extra_n = 0, stall_left = 0, busy_bad = 0, tail = -1, cyc = 0;
        bit stalled = 1'b0, stall_bad = 1'b0;
        logic [BPS-1:0] held = '0;
        logic [BPS-1:0] e;
        aborted = 1'b0;
        bit_q.delete();
        exp_q.delete();
`ifdef LSB_EMBED_LEN_HEADER_EN
        begin : hdr_bits
            logic [LEN_W-1:0] lv;
            lv = LEN_W'(len);
            for (int i = LEN_W - 1; i >= 0; i--) bit_q.push_back(lv[i]);
        end
`endif
        for (int b = 0; b < len; b++) begin
            for (int i = 7; i >= 0; i--) bit_q.push_back(msg_q[b][i]);
        end
        while (cyc < 3000 && tail != 0) begin
            @(negedge in_clk);
            if (abort && out_bc_enable) begin
                in_rst_n = 1'b0;
                in_start = 1'b0;
                in_byte_valid = 1'b0;
                in_sample_valid = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (cyc > 0 && done_n == 0 && !out_done && !out_busy) busy_bad++;
            if (out_done) done_n++;
            if (out_bc_enable) begin
                en_n++;
                if (in_bc_ready) en_bad++;
            end
            if (out_byte_ready) bready_n++;

            in_start        = (cyc == 0);
            in_msg_len      = LEN_W'(len);
            in_byte_valid   = (byte_i < len);
            in_byte         = (byte_i < len) ? msg_q[byte_i] : 8'h00;
            in_sample_valid = (smp_i < smp_q.size());
            in_sample       = (smp_i < smp_q.size()) ? smp_q[smp_i] : '0;
            if (stall_left > 0) begin
                stall_left--;
            end else if (!stalled && stall_at >= 0 && out_sample_valid && out_n == stall_at) begin
                stalled = 1'b1;
                stall_left = 20;
                held = out_sample;
            end
            in_dst_ready = (stall_left == 0);
            if (stall_left > 0 && (out_sample !== held || out_sample_ready || !out_sample_valid))
                stall_bad = 1'b1;

            if (in_byte_valid && out_byte_ready) byte_i++;
            if (in_sample_valid && out_sample_ready) begin
                if (smp_i < bit_q.size()) exp_q.push_back({in_sample[BPS-1:1], bit_q[smp_i]});
                else extra_n++;
                smp_i++;
            end
            if (out_sample_valid && in_dst_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("sample[%0d]", out_n), 64'(out_sample), 64'(e));
                end else begin
                    extra_n++;
                end
                out_n++;
            end
            if (tail > 0) tail--;
            else if (done_n > 0 && tail < 0) tail = 3;
            cyc++;
        end
        in_start = 1'b0;
        if (aborted) return;
        in_byte_valid = 1'b0;
        in_sample_valid = 1'b0;
        chk("done_count", 64'(done_n), 64'd1);
        chk("out_count", 64'(out_n), 64'(bit_q.size()));
        chk("leftover", 64'(exp_q.size()), 64'd0);
        chk("extra", 64'(extra_n), 64'd0);
        chk("enable_count", 64'(en_n), 64'(bit_q.size()));
        chk("enable_while_ready", 64'(en_bad), 64'd0);
        chk("byte_ready_cycles", 64'(bready_n), 64'(len));
        chk("busy_gap", 64'(busy_bad), 64'd0);
        chk("busy_after_done", 64'(out_busy), 64'd0);
        if (stall_at >= 0) begin
            chk("stall_taken", 64'(stalled), 64'd1);
            chk("stall_stable", 64'(stall_bad), 64'd0);
        end
    endtask

    initial begin
        bit ab;
        int done_seen;
        repeat (3) @(negedge in_clk);
        chk_zero("reset");
        in_rst_n = 1'b1;

        msg_q = '{8'hA5};
        smp_q.delete();
        for (int i = 0; i < 64; i++) smp_q.push_back(BPS'(i));
        run_msg(1, -1, 1'b0, ab);

        msg_q = '{8'hFF, 8'h00};
        smp_q.delete();
        for (int i = 0; i < 64; i++) smp_q.push_back(24'hFFFFFE);
        run_msg(2, -1, 1'b0, ab);

        msg_q = '{8'hC3, 8'h5E};
        smp_q.delete();
        for (int i = 0; i < 64; i++) smp_q.push_back(BPS'($urandom()));
        run_msg(2, 5, 1'b0, ab);

        hold_cfg = 8;
        msg_q = '{8'h3C};
        run_msg(1, -1, 1'b0, ab);
        hold_cfg = 1;

        msg_q.delete();
        run_msg(0, -1, 1'b0, ab);

        msg_q = '{8'h5A};
        run_msg(1, -1, 1'b1, ab);
        chk("abort_reached", 64'(ab), 64'd1);
        @(negedge in_clk);
        chk_zero("abort");
        in_rst_n = 1'b1;
        done_seen = 0;
        repeat (10) begin
            @(negedge in_clk);
            if (out_done) done_seen++;
        end
        chk("no_done_after_abort", 64'(done_seen), 64'd0);

        msg_q = '{8'h96};
        run_msg(1, -1, 1'b0, ab);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
